// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : MAR/MDR memory interface with a fixed-latency access FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
    parameter int WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bus_in,
    input  logic        ld_mar,
    input  logic        ld_mdr,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mar,
    output logic [15:0] mdr,
    output logic        ready_bit,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_ce,
    output logic        mem_we,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_DONE    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] c_LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        dir_q,   dir_d;
    logic [15:0] mar_q,   mar_d;
    logic [15:0] mdr_q,   mdr_d;
    logic        w_bus_window;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            dir_q   <= 1'b0;
            mar_q   <= 16'h0000;
            mdr_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
        end
    end

    // Bus loads are only honoured while no access owns the address/data path.
    assign w_bus_window = (state_q == S_IDLE) || (state_q == S_RELEASE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;

        if (ld_mar && w_bus_window)
            mar_d = bus_in;
        if (ld_mdr && !mio_en && w_bus_window)
            mdr_d = bus_in;

        case (state_q)
            S_IDLE: begin
                if (mio_en) begin
                    dir_d   = r_w;
                    cnt_d   = 4'd0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == c_LAST_CNT) begin
                    state_d = S_DONE;
                    if (!dir_q)
                        mdr_d = mem_rdata;
                end
            end
            S_DONE: begin
                state_d = mio_en ? S_RELEASE : S_IDLE;
            end
            S_RELEASE: begin
                if (!mio_en)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mar       = mar_q;
    assign mdr       = mdr_q;
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;
    assign ready_bit = (state_q == S_DONE);
    assign mem_ce    = (state_q == S_ACCESS);
    assign mem_we    = (state_q == S_ACCESS) && dir_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Directed scoreboard bench for mem_ctrl (WAIT_CYCLES 3 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bus_in;
    logic        ld_mar, ld_mdr, mio_en, mio_en_b, r_w;
    logic [15:0] mem_rdata;

    logic [15:0] mar_a, mdr_a, addr_a, wdata_a;
    logic        rdy_a, ce_a, we_a, busy_a;
    logic [15:0] mar_b, mdr_b, addr_b, wdata_b;
    logic        rdy_b, ce_b, we_b, busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_ctrl #(.WAIT_CYCLES(3)) dut_a (
        .clk(clk), .reset(reset), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
        .mio_en(mio_en), .r_w(r_w), .mem_rdata(mem_rdata),
        .mar(mar_a), .mdr(mdr_a), .ready_bit(rdy_a), .mem_addr(addr_a),
        .mem_wdata(wdata_a), .mem_ce(ce_a), .mem_we(we_a), .busy(busy_a)
    );

    mem_ctrl #(.WAIT_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
        .mio_en(mio_en_b), .r_w(r_w), .mem_rdata(mem_rdata),
        .mar(mar_b), .mdr(mdr_b), .ready_bit(rdy_b), .mem_addr(addr_b),
        .mem_wdata(wdata_b), .mem_ce(ce_b), .mem_we(we_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every ready pulse of the WAIT_CYCLES=3 instance must match a queued access.
    always @(negedge clk) begin
        if (rdy_a === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_ready", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_mar", {16'h0, mar_a}, {16'h0, e.addr});
                check("sb_mdr", {16'h0, mdr_a}, {16'h0, e.data});
            end
        end
    end

    task automatic do_access(input bit sel, input bit wr, input logic [15:0] rdata,
                             input int hold, input bit meddle,
                             input logic [15:0] exp_addr, input logic [15:0] exp_wdata,
                             output int lat, output int ce_n, output int we_n,
                             output int pulses, output bit addr_ok, output bit busy_at_hold);
        logic o_ce, o_we, o_rdy, o_busy;
        logic [15:0] o_addr, o_wdata;
        lat = -1; ce_n = 0; we_n = 0; pulses = 0; addr_ok = 1'b1; busy_at_hold = 1'b0;
        r_w = wr;
        mem_rdata = rdata;
        if (sel) mio_en_b = 1'b1; else mio_en = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            o_ce    = sel ? ce_b    : ce_a;
            o_we    = sel ? we_b    : we_a;
            o_rdy   = sel ? rdy_b   : rdy_a;
            o_busy  = sel ? busy_b  : busy_a;
            o_addr  = sel ? addr_b  : addr_a;
            o_wdata = sel ? wdata_b : wdata_a;
            if (o_ce === 1'b1) begin
                ce_n++;
                if (o_addr !== exp_addr || (wr && o_wdata !== exp_wdata)) addr_ok = 1'b0;
            end
            if (o_we === 1'b1) we_n++;
            if (o_rdy === 1'b1) begin
                pulses++;
                if (lat < 0) lat = k;
            end
            if (k == hold) busy_at_hold = o_busy;
            if (meddle && k == 1) begin
                ld_mar = 1'b1; ld_mdr = 1'b1; bus_in = 16'hFFFF;
            end
            if (meddle && k == 3) begin
                ld_mar = 1'b0; ld_mdr = 1'b0;
            end
            if (k >= hold) begin
                if (sel) mio_en_b = 1'b0; else mio_en = 1'b0;
            end
            if (k > hold && o_busy === 1'b0) break;
        end
        check("access_returns_idle", {31'd0, (sel ? busy_b : busy_a)}, 32'd0);
    endtask

    initial begin
        int lat, ce_n, we_n, pulses, extra;
        bit addr_ok, busy_h;

        reset = 1'b0; bus_in = 16'h0; ld_mar = 1'b0; ld_mdr = 1'b0;
        mio_en = 1'b0; mio_en_b = 1'b0; r_w = 1'b0; mem_rdata = 16'h0;
        repeat (2) @(negedge clk);
        check("rst_mar",  {16'h0, mar_a}, 32'h0);
        check("rst_mdr",  {16'h0, mdr_a}, 32'h0);
        check("rst_outs", {28'h0, rdy_a, ce_a, we_a, busy_a}, 32'h0);
        reset = 1'b1;

        // Read at 0x3000
        @(negedge clk);
        bus_in = 16'h3000; ld_mar = 1'b1;
        @(negedge clk);
        ld_mar = 1'b0;
        check("ld_mar_addr", {16'h0, addr_a}, 32'h3000);
        sb.push_back('{addr: 16'h3000, data: 16'hBEEF});
        do_access(1'b0, 1'b0, 16'hBEEF, 1, 1'b0, 16'h3000, 16'h0,
                  lat, ce_n, we_n, pulses, addr_ok, busy_h);
        check("rd_latency", 32'(lat), 32'd4);
        check("rd_ce_cycles", 32'(ce_n), 32'd3);
        check("rd_we_cycles", 32'(we_n), 32'd0);
        check("rd_pulses", 32'(pulses), 32'd1);
        check("rd_addr_stable", {31'd0, addr_ok}, 32'd1);

        // Write 0x1234 to 0x3001
        @(negedge clk);
        bus_in = 16'h3001; ld_mar = 1'b1;
        @(negedge clk);
        bus_in = 16'h1234; ld_mar = 1'b0; ld_mdr = 1'b1;
        @(negedge clk);
        ld_mdr = 1'b0;
        check("ld_mdr_wdata", {16'h0, wdata_a}, 32'h1234);
        sb.push_back('{addr: 16'h3001, data: 16'h1234});
        do_access(1'b0, 1'b1, 16'hAAAA, 1, 1'b0, 16'h3001, 16'h1234,
                  lat, ce_n, we_n, pulses, addr_ok, busy_h);
        check("wr_ce_cycles", 32'(ce_n), 32'd3);
        check("wr_we_cycles", 32'(we_n), 32'd3);
        check("wr_pulses", 32'(pulses), 32'd1);
        check("wr_addr_data", {31'd0, addr_ok}, 32'd1);

        // mio_en held for 20 cycles gives one access, then a fresh one
        sb.push_back('{addr: 16'h3001, data: 16'h5A5A});
        do_access(1'b0, 1'b0, 16'h5A5A, 20, 1'b0, 16'h3001, 16'h0,
                  lat, ce_n, we_n, pulses, addr_ok, busy_h);
        check("hold_pulses", 32'(pulses), 32'd1);
        check("hold_ce_cycles", 32'(ce_n), 32'd3);
        check("hold_in_release", {31'd0, busy_h}, 32'd1);
        sb.push_back('{addr: 16'h3001, data: 16'h0F0F});
        do_access(1'b0, 1'b0, 16'h0F0F, 1, 1'b0, 16'h3001, 16'h0,
                  lat, ce_n, we_n, pulses, addr_ok, busy_h);
        check("second_pulses", 32'(pulses), 32'd1);

        // ld_mar/ld_mdr during a read's ACCESS are ignored
        sb.push_back('{addr: 16'h3001, data: 16'hC0DE});
        do_access(1'b0, 1'b0, 16'hC0DE, 1, 1'b1, 16'h3001, 16'h0,
                  lat, ce_n, we_n, pulses, addr_ok, busy_h);
        check("meddle_mar", {16'h0, mar_a}, 32'h3001);
        check("meddle_addr_stable", {31'd0, addr_ok}, 32'd1);
        check("meddle_mdr", {16'h0, mdr_a}, 32'hC0DE);

        // WAIT_CYCLES=1 instance
        @(negedge clk);
        bus_in = 16'h0042; ld_mar = 1'b1;
        @(negedge clk);
        ld_mar = 1'b0;
        do_access(1'b1, 1'b0, 16'h7777, 1, 1'b0, 16'h0042, 16'h0,
                  lat, ce_n, we_n, pulses, addr_ok, busy_h);
        check("w1_latency", 32'(lat), 32'd2);
        check("w1_ce_cycles", 32'(ce_n), 32'd1);
        check("w1_pulses", 32'(pulses), 32'd1);
        check("w1_mdr", {16'h0, mdr_b}, 32'h7777);

        // Asynchronous reset mid-ACCESS aborts the read
        @(negedge clk);
        r_w = 1'b0; mem_rdata = 16'hDEAD; mio_en = 1'b1;
        @(negedge clk);
        check("pre_abort_ce", {31'd0, ce_a}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_mar", {16'h0, mar_a}, 32'h0);
        check("abort_mdr", {16'h0, mdr_a}, 32'h0);
        check("abort_outs", {28'h0, rdy_a, ce_a, we_a, busy_a}, 32'h0);
        mio_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (rdy_a === 1'b1) extra++;
        end
        check("abort_no_ready", 32'(extra), 32'd0);
        check("abort_mdr_after", {16'h0, mdr_a}, 32'h0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
